// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter, one shift per clock.
// Result is registered and only updated when a conversion completes, so the displays never see partial values.
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iSTART,
  input  logic [BIN_W-1:0]      iBIN,
  output logic                  oBUSY,
  output logic                  oDONE,
  output logic [4*DIGITS-1:0]   oBCD
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam int SW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [BIN_W-1:0] bin_sr;
  logic [SW-1:0]    scratch;
  logic [CW-1:0]    count;

  logic [SW-1:0]       adj;
  logic [SW+BIN_W-1:0] shifted;

  // All nibbles are corrected in parallel from the current scratch value.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
    shifted = {adj[SW-2:0], bin_sr, 1'b0};
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= IDLE;
      bin_sr  <= '0;
      scratch <= '0;
      count   <= '0;
      oBUSY   <= 1'b0;
      oDONE   <= 1'b0;
      oBCD    <= '0;
    end else begin
      oDONE <= 1'b0;
      case (state)
        IDLE: begin
          if (iSTART) begin
            bin_sr  <= iBIN;
            scratch <= '0;
            count   <= CW'(BIN_W);
            oBUSY   <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted[SW+BIN_W-1:BIN_W];
          bin_sr  <= shifted[BIN_W-1:0];
          count   <= count - CW'(1);
          if (count == CW'(1))
            state <= DONE;
        end
        DONE: begin
          // Publish the result and done pulse together as the converter drops back to idle.
          oBCD  <= scratch;
          oDONE <= 1'b1;
          oBUSY <= 1'b0;
          state <= IDLE;
        end
        default: begin
          oBUSY <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: table vectors, multi-cycle corner sequences and random values against a decimal-split model.
module tb_bin2bcd_seq;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iSTART = 1'b0;
  logic [15:0] iBIN = '0;
  logic        oBUSY;
  logic        oDONE;
  logic [19:0] oBCD;

  int total = 0;
  int bad = 0;

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iBIN(iBIN),
    .oBUSY(oBUSY), .oDONE(oDONE), .oBCD(oBCD)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic nibbles_ok(input logic [19:0] b);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 5; i++)
      if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // One full conversion: checks latency, busy length, result and nibble range.
  task automatic convert(input logic [15:0] v, input logic [19:0] exp, input string nm);
    int busy_n;
    int lat;
    busy_n = 0;
    lat = -1;
    @(negedge iCLK);
    iSTART = 1'b1;
    iBIN = v;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    iBIN = 16'($urandom);
    if (oBUSY) busy_n++;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge iCLK); #1;
      if (oBUSY) busy_n++;
      if (oDONE) lat = k;
    end
    check({nm, "_latency"}, lat, 17);
    check({nm, "_busy"}, busy_n, 17);
    check({nm, "_bcd"}, {12'd0, oBCD}, {12'd0, exp});
    check({nm, "_nibbles"}, {31'd0, nibbles_ok(oBCD)}, 32'd1);
  endtask

  initial begin
    int done_k[$];
    logic [19:0] first_bcd;
    logic [19:0] hold_bcd;
    int n_done;

    vecs[0]  = '{16'd1234,  20'h01234};
    vecs[1]  = '{16'd0,     20'h00000};
    vecs[2]  = '{16'd65535, 20'h65535};
    vecs[3]  = '{16'd1,     20'h00001};
    vecs[4]  = '{16'd9,     20'h00009};
    vecs[5]  = '{16'd10,    20'h00010};
    vecs[6]  = '{16'd99,    20'h00099};
    vecs[7]  = '{16'd100,   20'h00100};
    vecs[8]  = '{16'd9999,  20'h09999};
    vecs[9]  = '{16'd10000, 20'h10000};
    vecs[10] = '{16'd59999, 20'h59999};
    vecs[11] = '{16'd32768, 20'h32768};

    // Reset asserted between clock edges must clear outputs immediately.
    #2 iRST = 1'b1;
    #1;
    check("rst_bcd", {12'd0, oBCD}, 32'd0);
    check("rst_busy", {31'd0, oBUSY}, 32'd0);
    check("rst_done", {31'd0, oDONE}, 32'd0);
    @(negedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    repeat (3) @(negedge iCLK);
    check("idle_bcd", {12'd0, oBCD}, 32'd0);
    check("idle_busy", {31'd0, oBUSY}, 32'd0);
    check("idle_done", {31'd0, oDONE}, 32'd0);

    for (int i = 0; i < 12; i++)
      convert(vecs[i].bin, vecs[i].bcd, $sformatf("vec%0d", i));

    // Held start: back-to-back conversions, second one uses the changed input.
    @(negedge iCLK);
    iSTART = 1'b1;
    iBIN = 16'd9;
    first_bcd = '0;
    hold_bcd = '0;
    @(posedge iCLK); #1;
    iBIN = 16'd10;
    for (int k = 1; k <= 40 && done_k.size() < 2; k++) begin
      @(posedge iCLK); #1;
      if (oDONE) begin
        done_k.push_back(k);
        if (done_k.size() == 1) first_bcd = oBCD;
        else iSTART = 1'b0;
      end
      if (k == 20) hold_bcd = oBCD;
    end
    iSTART = 1'b0;
    check("held_count", done_k.size(), 2);
    if (done_k.size() == 2) begin
      check("held_first_at", done_k[0], 17);
      check("held_gap", done_k[1] - done_k[0], 18);
    end
    check("held_first_bcd", {12'd0, first_bcd}, 32'h00009);
    check("held_hold_bcd", {12'd0, hold_bcd}, 32'h00009);
    check("held_second_bcd", {12'd0, oBCD}, 32'h00010);
    repeat (20) @(posedge iCLK);
    #1 check("held_idle", {31'd0, oBUSY}, 32'd0);

    // Start pulses during a conversion and in its final busy cycle are ignored.
    @(negedge iCLK);
    iSTART = 1'b1;
    iBIN = 16'd42;
    n_done = 0;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge iCLK); #1;
      iSTART = 1'b0;
      if (oDONE) begin
        n_done++;
        check("ign_done_at", k, 17);
        check("ign_bcd", {12'd0, oBCD}, 32'h00042);
      end
      if (k == 5 || k == 16) begin
        iSTART = 1'b1;
        iBIN = 16'd999;
      end
    end
    check("ign_done_count", n_done, 1);
    check("ign_idle", {31'd0, oBUSY}, 32'd0);

    // Reset in the middle of a conversion abandons it.
    @(negedge iCLK);
    iSTART = 1'b1;
    iBIN = 16'd500;
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    repeat (8) @(posedge iCLK);
    #1 iRST = 1'b1;
    #2;
    check("midrst_bcd", {12'd0, oBCD}, 32'd0);
    check("midrst_busy", {31'd0, oBUSY}, 32'd0);
    @(negedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    n_done = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge iCLK); #1;
      if (oDONE) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    check("midrst_bcd_after", {12'd0, oBCD}, 32'd0);
    convert(16'd7, 20'h00007, "after_rst");

    // Random values against the decimal-split model.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      convert(v, ref_bcd(v), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
